simulador_esteira_garrafa: RTL

//   Plant-side model of the wine-bottle conveyor: the responder to the process/motor FSMs.

---
 rtl/simulador_esteira_garrafa.sv | 134 +++++++++++++
 1 files changed

// File: rtl/simulador_esteira_garrafa.sv
// Plant model of the wine-bottle conveyor: turns motor/valve/actuator
// commands into station, fill-level and status sensors for the controller.
module simulador_esteira_garrafa #(
    parameter int unsigned PASSOS_ENTRE_ESTACOES = 8,
    parameter int unsigned TICKS_ENCHIMENTO      = 5
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_passo_en,
    input  logic       i_motor,
    input  logic       i_valvula_enchimento,
    input  logic       i_atuador_vedacao,
    output logic       o_sensor_pos_enchimento,
    output logic       o_sensor_pos_cq,
    output logic       o_sensor_pos_lacre,
    output logic       o_sensor_garrafa_cheia,
    output logic       o_garrafa_vedada,
    output logic       o_erro_derrame,
    output logic [1:0] o_estacao,
    output logic [7:0] o_garrafas_concluidas
);

    localparam int unsigned DIST_W  = $clog2(PASSOS_ENTRE_ESTACOES);
    localparam int unsigned NIVEL_W = $clog2(TICKS_ENCHIMENTO + 1);
    localparam int unsigned CNT_W   = 8;

    localparam logic [DIST_W-1:0]  DIST_MAX  = DIST_W'(PASSOS_ENTRE_ESTACOES - 1);
    localparam logic [NIVEL_W-1:0] NIVEL_MAX = NIVEL_W'(TICKS_ENCHIMENTO);

    typedef enum logic [1:0] {
        ENTRADA    = 2'd0,
        ENCHIMENTO = 2'd1,
        CQ         = 2'd2,
        LACRE      = 2'd3
    } estacao_t;

    estacao_t           r_estacao,  w_estacao_next;
    logic [DIST_W-1:0]  r_dist,     w_dist_next;
    logic [NIVEL_W-1:0] r_nivel,    w_nivel_next;
    logic               r_vedada,   w_vedada_next;
    logic               r_erro,     w_erro_next;
    logic [CNT_W-1:0]   r_cnt,      w_cnt_next;

    // Sensor flops hold the decode of the state they accompany, so they
    // line up with the state registers without adding latency.
    logic               r_sens_ench, r_sens_cq, r_sens_lacre, r_sens_cheia;

    logic               w_alinhado_ench;
    logic               w_cheia;

    assign w_alinhado_ench = (r_estacao == ENCHIMENTO) && (r_dist == '0);
    assign w_cheia         = (r_nivel == NIVEL_MAX);

    // State register: conveyor position, fill level, flags and sensor decode
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_estacao    <= ENTRADA;
            r_dist       <= '0;
            r_nivel      <= '0;
            r_vedada     <= 1'b0;
            r_erro       <= 1'b0;
            r_cnt        <= '0;
            r_sens_ench  <= 1'b0;
            r_sens_cq    <= 1'b0;
            r_sens_lacre <= 1'b0;
            r_sens_cheia <= 1'b0;
        end else begin
            r_estacao    <= w_estacao_next;
            r_dist       <= w_dist_next;
            r_nivel      <= w_nivel_next;
            r_vedada     <= w_vedada_next;
            r_erro       <= w_erro_next;
            r_cnt        <= w_cnt_next;
            r_sens_ench  <= (w_estacao_next == ENCHIMENTO) && (w_dist_next == '0);
            r_sens_cq    <= (w_estacao_next == CQ)         && (w_dist_next == '0);
            r_sens_lacre <= (w_estacao_next == LACRE)      && (w_dist_next == '0);
            r_sens_cheia <= (w_nivel_next == NIVEL_MAX);
        end
    end

    // Next-state: movement, filling, spill detection and sealing on each step
    always_comb begin
        w_estacao_next = r_estacao;
        w_dist_next    = r_dist;
        w_nivel_next   = r_nivel;
        w_vedada_next  = r_vedada;
        w_erro_next    = r_erro;
        w_cnt_next     = r_cnt;

        if (i_passo_en) begin
            if (i_motor) begin
                if (r_dist == DIST_MAX) begin
                    w_dist_next = '0;
                    case (r_estacao)
                        ENTRADA:    w_estacao_next = ENCHIMENTO;
                        ENCHIMENTO: w_estacao_next = CQ;
                        CQ:         w_estacao_next = LACRE;
                        default: begin
                            // Leaving LACRE: the finished bottle is replaced by an empty one
                            w_estacao_next = ENTRADA;
                            w_nivel_next   = '0;
                            w_vedada_next  = 1'b0;
                            w_cnt_next     = CNT_W'(r_cnt + 1'b1);
                        end
                    endcase
                end else begin
                    w_dist_next = DIST_W'(r_dist + 1'b1);
                end
            end

            if (i_valvula_enchimento) begin
                if (i_motor || !w_alinhado_ench || w_cheia) begin
                    w_erro_next = 1'b1;
                end else begin
                    w_nivel_next = NIVEL_W'(r_nivel + 1'b1);
                end
            end

            if (i_atuador_vedacao && !i_motor && w_alinhado_ench && w_cheia) begin
                w_vedada_next = 1'b1;
            end
        end
    end

    assign o_sensor_pos_enchimento = r_sens_ench;
    assign o_sensor_pos_cq         = r_sens_cq;
    assign o_sensor_pos_lacre      = r_sens_lacre;
    assign o_sensor_garrafa_cheia  = r_sens_cheia;
    assign o_garrafa_vedada        = r_vedada;
    assign o_erro_derrame          = r_erro;
    assign o_estacao               = r_estacao;
    assign o_garrafas_concluidas   = r_cnt;

endmodule
